// File: rtl/controle_votacao.sv
// controle_votacao: day-phase voting sequencer.
//
// After a night round this block polls every living player in index order, waits for one
// validated vote per player from the selection converter, pulses the converter clear after
// each accepted vote and tallies votes per target. When all living players have voted it
// scans the tallies (one per cycle) and reports the eliminated player or a no-elimination
// result.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   iniciar          in   start pulse, honoured only when idle or finished
//   vivos            in   alive mask (bit i = player i alive), latched on start
//   voto_valido      in   one-cycle strobe qualifying voto
//   voto             in   vote target index or abstention code
//   jogador_votante  out  index of the player being polled
//   aguardando_voto  out  high while waiting for the current player's vote
//   reset_convertor  out  one-cycle clear pulse after each accepted vote
//   fim              out  result valid; held until restart or reset
//   eliminado        out  eliminated player index, or the "nobody" code
//   empate           out  high in the finished state when nobody is eliminated
//   votos_contados   out  accepted votes this round, abstentions included
//   db_estado        out  state code for the debug display
module controle_votacao #(
  parameter int unsigned N_JOGADORES = 5,
  parameter int unsigned W_IDX       = 3,
  parameter int unsigned COD_PULAR   = 5,
  parameter int unsigned COD_NENHUM  = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic                   voto_valido,
  input  logic [W_IDX-1:0]       voto,
  output logic [W_IDX-1:0]       jogador_votante,
  output logic                   aguardando_voto,
  output logic                   reset_convertor,
  output logic                   fim,
  output logic [W_IDX-1:0]       eliminado,
  output logic                   empate,
  output logic [W_IDX-1:0]       votos_contados,
  output logic [3:0]             db_estado
);

  // A tally never exceeds the number of players, so this width cannot overflow.
  localparam int unsigned TallyW = $clog2(N_JOGADORES + 1);
  // Alive mask padded to every code representable on W_IDX bits, so any vote or
  // index value can be looked up without an out-of-range select.
  localparam int unsigned ExtW = 2 ** W_IDX;

  localparam logic [W_IDX-1:0] CodPular  = W_IDX'(COD_PULAR);
  localparam logic [W_IDX-1:0] CodNenhum = W_IDX'(COD_NENHUM);
  localparam logic [W_IDX-1:0] NJog      = W_IDX'(N_JOGADORES);
  localparam logic [W_IDX-1:0] UltimoIdx = W_IDX'(N_JOGADORES - 1);

  typedef enum logic [2:0] {
    StOcioso   = 3'd0,
    StProcura  = 3'd1,
    StEspera   = 3'd2,
    StRegistra = 3'd3,
    StLibera   = 3'd4,
    StApura    = 3'd5,
    StFim      = 3'd6
  } estado_e;

  estado_e                estado_q;
  logic [W_IDX-1:0]       idx_q;
  logic [N_JOGADORES-1:0] vivos_q;
  logic [W_IDX-1:0]       voto_q;
  logic [TallyW-1:0]      tally_q [N_JOGADORES];
  logic [TallyW-1:0]      abst_q;
  logic [W_IDX-1:0]       votos_q;

  // Scan state used while counting the result.
  logic [W_IDX-1:0]       scan_q;
  logic [TallyW-1:0]      max_q;
  logic [W_IDX-1:0]       cand_q;
  logic                   tie_q;

  // Registered outputs.
  logic                   aguardando_q;
  logic                   reset_conv_q;
  logic                   fim_q;
  logic [W_IDX-1:0]       eliminado_q;
  logic                   empate_q;

  logic [ExtW-1:0]        vivos_ext;
  logic                   voto_aceito;
  logic [TallyW-1:0]      tally_scan;
  logic [TallyW-1:0]      max_d;
  logic [W_IDX-1:0]       cand_d;
  logic                   tie_d;

  assign vivos_ext = ExtW'(vivos_q);

  // Abstentions are always valid; a player vote must target a living, in-range index.
  assign voto_aceito = voto_valido &&
                       ((voto == CodPular) || ((voto < NJog) && vivos_ext[voto]));

  // Tally currently under the scan pointer.
  always_comb begin
    tally_scan = '0;
    for (int i = 0; i < int'(N_JOGADORES); i++) begin
      if (scan_q == W_IDX'(i)) begin
        tally_scan = tally_q[i];
      end
    end
  end

  // One scan step: a strictly larger tally takes over and clears the tie; an equal non-zero
  // tally marks a tie. The first maximum found keeps the candidate slot.
  always_comb begin
    max_d  = max_q;
    cand_d = cand_q;
    tie_d  = tie_q;
    if (tally_scan > max_q) begin
      max_d  = tally_scan;
      cand_d = scan_q;
      tie_d  = 1'b0;
    end else if ((tally_scan == max_q) && (max_q != '0)) begin
      tie_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= StOcioso;
      idx_q        <= '0;
      vivos_q      <= '0;
      voto_q       <= '0;
      for (int i = 0; i < int'(N_JOGADORES); i++) begin
        tally_q[i] <= '0;
      end
      abst_q       <= '0;
      votos_q      <= '0;
      scan_q       <= '0;
      max_q        <= '0;
      cand_q       <= '0;
      tie_q        <= 1'b0;
      aguardando_q <= 1'b0;
      reset_conv_q <= 1'b0;
      fim_q        <= 1'b0;
      eliminado_q  <= CodNenhum;
      empate_q     <= 1'b0;
    end else begin
      // The converter clear is a single-cycle pulse unless re-armed below.
      reset_conv_q <= 1'b0;

      unique case (estado_q)
        StOcioso, StFim: begin
          if (iniciar) begin
            estado_q    <= StProcura;
            idx_q       <= '0;
            vivos_q     <= vivos;
            for (int i = 0; i < int'(N_JOGADORES); i++) begin
              tally_q[i] <= '0;
            end
            abst_q      <= '0;
            votos_q     <= '0;
            fim_q       <= 1'b0;
            eliminado_q <= CodNenhum;
            empate_q    <= 1'b0;
          end
        end

        StProcura: begin
          if (idx_q == NJog) begin
            estado_q <= StApura;
            scan_q   <= '0;
            max_q    <= '0;
            cand_q   <= '0;
            tie_q    <= 1'b0;
          end else if (vivos_ext[idx_q]) begin
            estado_q     <= StEspera;
            aguardando_q <= 1'b1;
          end else begin
            // Dead player: skip one index per cycle.
            idx_q <= idx_q + 1'b1;
          end
        end

        StEspera: begin
          if (voto_aceito) begin
            voto_q       <= voto;
            aguardando_q <= 1'b0;
            estado_q     <= StRegistra;
          end
        end

        StRegistra: begin
          if (voto_q == CodPular) begin
            abst_q <= abst_q + 1'b1;
          end else begin
            for (int i = 0; i < int'(N_JOGADORES); i++) begin
              if (voto_q == W_IDX'(i)) begin
                tally_q[i] <= tally_q[i] + 1'b1;
              end
            end
          end
          votos_q      <= votos_q + 1'b1;
          reset_conv_q <= 1'b1;
          estado_q     <= StLibera;
        end

        StLibera: begin
          idx_q    <= idx_q + 1'b1;
          estado_q <= StProcura;
        end

        StApura: begin
          max_q  <= max_d;
          cand_q <= cand_d;
          tie_q  <= tie_d;
          if (scan_q == UltimoIdx) begin
            estado_q <= StFim;
            fim_q    <= 1'b1;
            // Abstentions are kept apart from the tallies, so they can never eliminate.
            if ((max_d == '0) || tie_d) begin
              empate_q    <= 1'b1;
              eliminado_q <= CodNenhum;
            end else begin
              empate_q    <= 1'b0;
              eliminado_q <= cand_d;
            end
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end

        default: begin
          estado_q <= StOcioso;
        end
      endcase
    end
  end

  assign jogador_votante = idx_q;
  assign aguardando_voto = aguardando_q;
  assign reset_convertor = reset_conv_q;
  assign fim             = fim_q;
  assign eliminado       = eliminado_q;
  assign empate          = empate_q;
  assign votos_contados  = votos_q;
  assign db_estado       = {1'b0, estado_q};

endmodule
